reduce_slot_engine: RTL and testbench

Parametrised reduction-table engine for the MPI collective router. It accumulates per-index contributions from child nodes into a table of `SLOTS` entries, using a pipelined integer ALU with a selectable operation. Each completed reduction is emitted on a valid/ready output queue toward the next node or the host. Successor of the fixed two-slot, adder-only table: it adds configurable depth and latency, six ops, per-source duplicate rejection, and back-pressure on both sides.

---
 rtl/reduce_slot_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_reduce_slot_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_slot_engine.sv
// rtl/reduce_slot_engine.sv - per-index reduction table with pipelined ALU and output queue
// Slots accumulate child contributions; completed reductions leave through a small FIFO.
module reduce_slot_engine #(
  parameter int SLOTS     = 4,
  parameter int IDX_W     = 4,
  parameter int PW        = 32,
  parameter int SRC_W     = 3,
  parameter int CH_W      = 3,
  parameter int ALU_LAT   = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic [SRC_W-1:0] in_src,
  input  logic [CH_W-1:0]  in_children,
  input  logic [2:0]       in_op,
  input  logic [SRC_W-1:0] in_dst,
  input  logic [SRC_W-1:0] in_rank,
  input  logic [PW-1:0]    in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [SRC_W-1:0] out_src,
  output logic [SRC_W-1:0] out_dst,
  output logic [PW-1:0]    out_payload,
  output logic             err,
  output logic [15:0]      dup_count
);
  localparam int NSRC = 1 << SRC_W;
  localparam int QAW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int QCW  = $clog2(OUT_DEPTH + 1);

  function automatic logic [PW-1:0] alu(input logic [2:0] op, input logic [PW-1:0] a,
                                        input logic [PW-1:0] b);
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = ($signed(a) > $signed(b)) ? a : b;
      3'd2:    alu = ($signed(a) < $signed(b)) ? a : b;
      3'd3:    alu = a & b;
      3'd4:    alu = a | b;
      3'd5:    alu = a ^ b;
      default: alu = a;
    endcase
  endfunction

  logic [SLOTS-1:0]            slot_valid_q, slot_valid_d, slot_busy_q, slot_busy_d;
  logic [SLOTS-1:0][PW-1:0]    slot_acc_q, slot_acc_d;
  logic [SLOTS-1:0][2:0]       slot_op_q, slot_op_d;
  logic [SLOTS-1:0][SRC_W-1:0] slot_dst_q, slot_dst_d, slot_rank_q, slot_rank_d;
  logic [SLOTS-1:0][CH_W-1:0]  slot_rem_q, slot_rem_d;
  logic [SLOTS-1:0][NSRC-1:0]  slot_mask_q, slot_mask_d;

  logic [ALU_LAT-1:0]            pipe_v_q, pipe_v_d;
  logic [ALU_LAT-1:0][IDX_W-1:0] pipe_idx_q, pipe_idx_d;
  logic [ALU_LAT-1:0][PW-1:0]    pipe_res_q, pipe_res_d;

  logic [OUT_DEPTH-1:0][IDX_W-1:0] q_idx_q, q_idx_d;
  logic [OUT_DEPTH-1:0][SRC_W-1:0] q_src_q, q_src_d, q_dst_q, q_dst_d;
  logic [OUT_DEPTH-1:0][PW-1:0]    q_pay_q, q_pay_d;
  logic [QAW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QCW-1:0]                  q_count_q, q_count_d;
  logic                            err_q, err_d;
  logic [15:0]                     dup_q, dup_d;

  logic [SLOTS-1:0] hit, wb_hit;
  logic             sel_valid, sel_busy;
  logic [PW-1:0]    sel_acc;
  logic [2:0]       sel_op;
  logic [NSRC-1:0]  sel_mask;
  logic [CH_W-1:0]  wb_rem;
  logic [SRC_W-1:0] wb_rank, wb_dst;
  logic [IDX_W-1:0] wb_idx;
  logic [PW-1:0]    wb_res;
  logic             wb_done, legal, room, accept, alloc, leaf, dup, issue, enq, pop;
  int               inflight;

  always_comb begin
    hit       = '0;
    wb_hit    = '0;
    sel_valid = 1'b0;
    sel_busy  = 1'b0;
    sel_acc   = '0;
    sel_op    = '0;
    sel_mask  = '0;
    wb_rem    = '0;
    wb_rank   = '0;
    wb_dst    = '0;
    wb_idx    = pipe_idx_q[ALU_LAT-1];
    wb_res    = pipe_res_q[ALU_LAT-1];
    inflight  = 0;
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]    = (int'(in_index) == i);
      wb_hit[i] = pipe_v_q[ALU_LAT-1] && (int'(wb_idx) == i);
      if (hit[i]) begin
        sel_valid = slot_valid_q[i];
        sel_busy  = slot_busy_q[i];
        sel_acc   = slot_acc_q[i];
        sel_op    = slot_op_q[i];
        sel_mask  = slot_mask_q[i];
      end
      if (wb_hit[i]) begin
        wb_rem  = slot_rem_q[i];
        wb_rank = slot_rank_q[i];
        wb_dst  = slot_dst_q[i];
      end
    end
    for (int s = 0; s < ALU_LAT; s++) begin
      if (pipe_v_q[s]) inflight = inflight + 1;
    end
  end

  // Reserving queue space for every in-flight op makes overflow impossible.
  assign legal    = (int'(in_index) < SLOTS) && (in_op <= 3'd5);
  assign wb_done  = pipe_v_q[ALU_LAT-1] && (wb_rem == CH_W'(1));
  assign room     = (int'(q_count_q) + inflight + 1) <= OUT_DEPTH;
  assign in_ready = !rst && !sel_busy && room && !(wb_done && (in_children == '0));
  assign accept   = in_valid && in_ready;
  assign alloc    = accept && legal && !sel_valid;
  assign leaf     = alloc && (in_children == '0);
  assign dup      = accept && legal && sel_valid && sel_mask[in_src];
  assign issue    = accept && legal && sel_valid && !sel_mask[in_src];
  assign enq      = leaf || wb_done;
  assign pop      = out_valid && out_ready;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_busy_d  = slot_busy_q;
    slot_acc_d   = slot_acc_q;
    slot_op_d    = slot_op_q;
    slot_dst_d   = slot_dst_q;
    slot_rank_d  = slot_rank_q;
    slot_rem_d   = slot_rem_q;
    slot_mask_d  = slot_mask_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (wb_hit[i]) begin
        slot_acc_d[i]  = wb_res;
        slot_rem_d[i]  = slot_rem_q[i] - CH_W'(1);
        slot_busy_d[i] = 1'b0;
        if (wb_done) begin
          slot_valid_d[i] = 1'b0;
          slot_mask_d[i]  = '0;
        end
      end
      if (hit[i] && alloc && !leaf) begin
        slot_valid_d[i] = 1'b1;
        slot_acc_d[i]   = in_payload;
        slot_op_d[i]    = in_op;
        slot_dst_d[i]   = in_dst;
        slot_rank_d[i]  = in_rank;
        slot_rem_d[i]   = in_children;
        slot_mask_d[i]  = NSRC'(1) << in_src;
      end
      if (hit[i] && issue) begin
        slot_busy_d[i] = 1'b1;
        slot_mask_d[i] = slot_mask_q[i] | (NSRC'(1) << in_src);
      end
    end
  end

  // The result is computed at issue and delayed so writeback lands ALU_LAT cycles later.
  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_res_d    = pipe_res_q;
    pipe_v_d[0]   = issue;
    pipe_idx_d[0] = in_index;
    pipe_res_d[0] = alu(sel_op, sel_acc, in_payload);
    for (int s = 1; s < ALU_LAT; s++) begin
      pipe_v_d[s]   = pipe_v_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
      pipe_res_d[s] = pipe_res_q[s-1];
    end
  end

  always_comb begin
    q_idx_d   = q_idx_q;
    q_src_d   = q_src_q;
    q_dst_d   = q_dst_q;
    q_pay_d   = q_pay_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    q_count_d = q_count_q + QCW'(enq) - QCW'(pop);
    if (enq) begin
      q_idx_d[wr_ptr_q] = leaf ? in_index : wb_idx;
      q_src_d[wr_ptr_q] = leaf ? in_rank : wb_rank;
      q_dst_d[wr_ptr_q] = leaf ? in_dst : wb_dst;
      q_pay_d[wr_ptr_q] = leaf ? in_payload : wb_res;
      wr_ptr_d = (wr_ptr_q == QAW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + QAW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == QAW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + QAW'(1);
    err_d = accept && !legal;
    dup_d = (dup && (dup_q != 16'hFFFF)) ? dup_q + 16'd1 : dup_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_busy_q  <= '0;
      slot_acc_q   <= '0;
      slot_op_q    <= '0;
      slot_dst_q   <= '0;
      slot_rank_q  <= '0;
      slot_rem_q   <= '0;
      slot_mask_q  <= '0;
      pipe_v_q     <= '0;
      pipe_idx_q   <= '0;
      pipe_res_q   <= '0;
      q_idx_q      <= '0;
      q_src_q      <= '0;
      q_dst_q      <= '0;
      q_pay_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_count_q    <= '0;
      err_q        <= 1'b0;
      dup_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_busy_q  <= slot_busy_d;
      slot_acc_q   <= slot_acc_d;
      slot_op_q    <= slot_op_d;
      slot_dst_q   <= slot_dst_d;
      slot_rank_q  <= slot_rank_d;
      slot_rem_q   <= slot_rem_d;
      slot_mask_q  <= slot_mask_d;
      pipe_v_q     <= pipe_v_d;
      pipe_idx_q   <= pipe_idx_d;
      pipe_res_q   <= pipe_res_d;
      q_idx_q      <= q_idx_d;
      q_src_q      <= q_src_d;
      q_dst_q      <= q_dst_d;
      q_pay_q      <= q_pay_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      q_count_q    <= q_count_d;
      err_q        <= err_d;
      dup_q        <= dup_d;
    end
  end

  assign out_valid   = (q_count_q != '0);
  assign out_index   = q_idx_q[rd_ptr_q];
  assign out_src     = q_src_q[rd_ptr_q];
  assign out_dst     = q_dst_q[rd_ptr_q];
  assign out_payload = q_pay_q[rd_ptr_q];
  assign err         = err_q;
  assign dup_count   = dup_q;
endmodule

// File: tb/tb_reduce_slot_engine.sv
// tb/tb_reduce_slot_engine.sv - directed and random checks of reduce_slot_engine against a table model
module tb_reduce_slot_engine;
  localparam int SLOTS = 4, IDX_W = 4, PW = 32, SRC_W = 3, CH_W = 3, ALU_LAT = 3, OUT_DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [IDX_W-1:0] in_index = '0;
  logic [SRC_W-1:0] in_src = '0, in_dst = '0, in_rank = '0;
  logic [CH_W-1:0] in_children = '0;
  logic [2:0] in_op = '0;
  logic [PW-1:0] in_payload = '0;
  logic out_valid, out_ready = 1'b1;
  logic [IDX_W-1:0] out_index;
  logic [SRC_W-1:0] out_src, out_dst;
  logic [PW-1:0] out_payload;
  logic err;
  logic [15:0] dup_count;

  reduce_slot_engine #(.SLOTS(SLOTS), .IDX_W(IDX_W), .PW(PW), .SRC_W(SRC_W), .CH_W(CH_W),
                       .ALU_LAT(ALU_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_src(in_src), .in_children(in_children), .in_op(in_op), .in_dst(in_dst),
    .in_rank(in_rank), .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_src(out_src), .out_dst(out_dst), .out_payload(out_payload),
    .err(err), .dup_count(dup_count));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference table: one entry per index, results applied in acceptance order.
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [SRC_W-1:0] src;
    logic [SRC_W-1:0] dst;
    logic [PW-1:0]    pay;
    int               due;
  } rec_t;
  rec_t expq[$];
  rec_t log_q[$];
  bit            m_valid[SLOTS];
  logic [PW-1:0] m_acc[SLOTS];
  int            m_op[SLOTS], m_rem[SLOTS], m_busy_until[SLOTS];
  bit [7:0]      m_mask[SLOTS];
  logic [SRC_W-1:0] m_rank[SLOTS], m_dst[SLOTS];
  int dup_exp;
  bit err_exp, mon_en = 0, rand_or = 0;

  function automatic logic [PW-1:0] ref_op(int op, logic [PW-1:0] a, logic [PW-1:0] b);
    case (op)
      0: return PW'(longint'(a) + longint'(b));
      1: return (int'(a) >= int'(b)) ? a : b;
      2: return (int'(a) <= int'(b)) ? a : b;
      3: return a & b;
      4: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 0; m_mask[i] = 0; m_busy_until[i] = -1;
    end
    expq.delete();
    dup_exp = 0;
    err_exp = 0;
  endtask

  task automatic push_exp(logic [IDX_W-1:0] idx, logic [SRC_W-1:0] src, logic [SRC_W-1:0] dst,
                          logic [PW-1:0] pay, int due);
    rec_t e;
    int k = 0;
    e.idx = idx; e.src = src; e.dst = dst; e.pay = pay; e.due = due;
    while (k < expq.size() && expq[k].due < due) k++;
    expq.insert(k, e);
  endtask

  task automatic model_accept();
    int i = int'(in_index);
    if (i >= SLOTS || in_op > 3'd5) begin
      err_exp = 1;
      return;
    end
    check("accept_while_busy", (cyc <= m_busy_until[i]), 0);
    if (!m_valid[i]) begin
      if (in_children == 0) push_exp(in_index, in_rank, in_dst, in_payload, cyc);
      else begin
        m_valid[i] = 1; m_acc[i] = in_payload; m_op[i] = int'(in_op);
        m_rem[i] = int'(in_children); m_mask[i] = 0; m_mask[i][in_src] = 1;
        m_rank[i] = in_rank; m_dst[i] = in_dst;
      end
    end else if (m_mask[i][in_src]) begin
      if (dup_exp < 65535) dup_exp++;
    end else begin
      m_mask[i][in_src] = 1;
      m_acc[i] = ref_op(m_op[i], m_acc[i], in_payload);
      m_rem[i]--;
      m_busy_until[i] = cyc + ALU_LAT;
      if (m_rem[i] == 0) begin
        push_exp(in_index, m_rank[i], m_dst[i], m_acc[i], cyc + ALU_LAT);
        m_valid[i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit due_now;
      rec_t r;
      due_now = (expq.size() > 0) && (expq[0].due < cyc);
      check("out_valid", out_valid, due_now);
      if (out_valid && due_now) begin
        check("out_index", out_index, expq[0].idx);
        check("out_src", out_src, expq[0].src);
        check("out_dst", out_dst, expq[0].dst);
        check("out_payload", out_payload, expq[0].pay);
      end
      check("err", err, err_exp);
      check("dup_count", dup_count, dup_exp);
      if (rst) begin
        check("in_ready_in_reset", in_ready, 0);
        model_reset();
      end else begin
        if (out_valid && out_ready) begin
          r.idx = out_index; r.src = out_src; r.dst = out_dst; r.pay = out_payload; r.due = cyc;
          log_q.push_back(r);
          if (due_now) void'(expq.pop_front());
        end
        err_exp = 0;
        if (in_valid && in_ready) model_accept();
      end
    end
  end

  always @(posedge clk) if (rand_or) begin
    #1 out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send(int idx, int src, int ch, int op, int dst, int rank, logic [PW-1:0] pay,
                      output int acc_cyc);
    bit ok = 0;
    in_index = IDX_W'(idx); in_src = SRC_W'(src); in_children = CH_W'(ch); in_op = 3'(op);
    in_dst = SRC_W'(dst); in_rank = SRC_W'(rank); in_payload = pay; in_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc; ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_log(int n);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (log_q.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("output_timeout", log_q.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_payload", out_payload, 0);
    check("rst_err", err, 0);
    check("rst_dup", dup_count, 0);
    check("rst_in_ready", in_ready, 0);
    mon_en = 1;
    rst = 1'b0;

    // Sum on slot 1
    send(1, 0, 2, 0, 2, 6, 32'd5, t1);
    send(1, 1, 2, 0, 2, 6, 32'd7, t2);
    send(1, 2, 2, 0, 2, 6, 32'd10, t3);
    wait_log(1);
    check("sum_payload", log_q[0].pay, 22);
    check("sum_index", log_q[0].idx, 1);
    check("sum_src_is_rank", log_q[0].src, 6);
    check("sum_dst", log_q[0].dst, 2);
    check("sum_latency", log_q[0].due - t3, ALU_LAT + 1);

    // Duplicate source rejected
    do_reset();
    send(2, 3, 1, 0, 1, 2, 32'd9, t1);
    send(2, 3, 1, 0, 1, 2, 32'd100, t1);
    send(2, 4, 1, 0, 1, 2, 32'd1, t1);
    wait_log(1);
    check("dup_payload", log_q[0].pay, 10);
    check("dup_count_one", dup_count, 1);

    // Signed max on slot 0, min on slot 3, interleaved
    do_reset();
    send(0, 0, 1, 1, 0, 1, 32'hFFFFFFFF, t1);
    send(3, 0, 1, 2, 0, 3, 32'hFFFFFFFF, t1);
    send(0, 1, 1, 1, 0, 1, 32'd2, t1);
    send(3, 1, 1, 2, 0, 3, 32'd2, t1);
    wait_log(2);
    check("max_index", log_q[0].idx, 0);
    check("max_payload", log_q[0].pay, 2);
    check("min_index", log_q[1].idx, 3);
    check("min_payload", log_q[1].pay, 32'hFFFFFFFF);

    // Back-pressure: fill the queue with leaves
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(i, i, 0, 0, 1, 2, 32'd100 + 32'(i), t1);
    in_index = '0; in_children = '0; in_op = '0; in_payload = 32'd200; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("full_in_ready_low", in_ready, 0);
    check("full_no_pop", log_q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(0, 0, 0, 0, 1, 2, 32'd200, t1);
    wait_log(5);
    for (int i = 0; i < 4; i++) check("bp_order", log_q[i].pay, 100 + i);
    check("bp_after_release", log_q[4].pay, 200);

    // Illegal index / op, then a leaf
    do_reset();
    send(5, 0, 0, 0, 1, 2, 32'd1, t1);
    @(negedge clk);
    check("err_pulse_index", err, 1);
    @(posedge clk); #1;
    send(1, 0, 0, 6, 1, 2, 32'd1, t1);
    @(negedge clk);
    check("err_pulse_op", err, 1);
    @(posedge clk); #1;
    send(0, 1, 0, 0, 3, 5, 32'hABCD, t2);
    wait_log(1);
    check("illegal_nothing_emitted", log_q.size(), 1);
    check("leaf_payload", log_q[0].pay, 32'hABCD);
    check("leaf_latency", log_q[0].due - t2, 1);

    // Reset with an op in flight on slot 1
    do_reset();
    send(1, 0, 1, 0, 1, 2, 32'd5, t1);
    send(1, 1, 1, 0, 1, 2, 32'd7, t1);
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_no_output", log_q.size(), 0);
    send(1, 0, 1, 0, 1, 2, 32'd3, t1);
    send(1, 1, 1, 0, 1, 2, 32'd4, t1);
    wait_log(1);
    check("rst_mid_fresh_sum", log_q[0].pay, 7);
    check("rst_mid_dup_zero", dup_count, 0);

    // Random traffic against the table model
    do_reset();
    rand_or = 1;
    for (int n = 0; n < 400; n++) begin
      int idx, op;
      idx = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, SLOTS - 1);
      op  = ($urandom_range(0, 19) == 0) ? 6 : $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(idx, $urandom_range(0, 4), $urandom_range(0, 3), op, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom, t1);
    end
    rand_or = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && expq.size() > 0; k++) @(negedge clk);
    check("random_drained", expq.size(), 0);
    check("random_outputs_seen", (log_q.size() > 20), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
